matmul2x2_sched: RTL and testbench
==================================

MATMUL2X2_SCHED -- requirements
Module: matmul2x2_sched

Interface
REQ-001 Parameter W, default 8: operand element width in bits.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles in WAIT before abort.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a_flat  input  4*W  matrix A; A[i][j] at bits [W*(2i+j) +: W].
REQ-007 b_flat  input  4*W  matrix B; same packing.
REQ-008 c_flat  output  4*(2W+1)  matrix C; C[i][j] at bits [(2W+1)*(2i+j) +: 2W+1].
REQ-009 busy  output  1  high from accept through the final WAIT.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  timeout flag.
REQ-012 mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-013 mul_a, mul_b  output  W each  multiplier operands.
REQ-014 mul_result  input  2W  multiplier product.
REQ-015 mul_done  input  1  multiplier completion strobe.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, FIN; the block computes C = A x B unsigned using 8 sequential products on one external multiplier.
REQ-017 IDLE: start=1 at a rising edge latches a_flat/b_flat into internal registers, clears err and product index p, and moves to ISSUE; busy=1 from the next cycle.
REQ-018 Products are ordered p=0..7, with element e=p>>1 (order C00, C01, C10, C11) and k=p&1; for e=(i,j), mul_a=A[i][k] and mul_b=B[k][j].
REQ-019 ISSUE: assert mul_start for exactly one cycle with mul_a/mul_b valid, then go to WAIT; mul_a/mul_b are held stable until mul_done is accepted.
REQ-020 WAIT: mul_done is accepted only in WAIT; any mul_done in IDLE, ISSUE or FIN is ignored.
REQ-021 On accept with k=0, the accumulator loads mul_result zero-extended to 2W+1 bits.
REQ-022 On accept with k=1, C[e] is written with accumulator + mul_result (2W+1 bits, no overflow possible); other C elements are unchanged.
REQ-023 After accept, p increments; if p was 7 go to FIN, else go to ISSUE, so the next mul_start occurs in the cycle after accept.
REQ-024 The WAIT cycle counter resets on each entry to WAIT; when it reaches TIMEOUT without mul_done, set err=1 and go to FIN; C retains any elements already written.
REQ-025 FIN: done=1 for one cycle and busy=0, then go to IDLE.
REQ-026 start while busy or in FIN is ignored; input changes after accept do not affect the result.
REQ-027 c_flat holds its last value until overwritten element-wise by the next operation.
REQ-028 err stays high until the next accepted start.
REQ-029 Minimum latency with 1-cycle multiplier: accept -> done = 8 x (ISSUE + WAIT) + FIN = 17 cycles.

Reset
REQ-030 rst=1 forces IDLE immediately, regardless of clock, and clears to 0: busy, done, err, mul_start, mul_a, mul_b, c_flat, p, accumulator, and WAIT counter.
REQ-031 Reset mid-operation abandons the computation; no done pulse is generated; a subsequent mul_done is ignored.

Verification
REQ-032 A=[[1,2],[3,4]], B=[[5,6],[7,8]], multiplier latency 3 -> C=[[19,22],[43,50]], single done pulse, err=0, exactly 8 mul_start pulses.
REQ-033 All elements 255 (W=8) -> every C element 130050 (0x1FC02), no truncation.
REQ-034 Multiplier never returns mul_done -> err=1 and done pulse exactly TIMEOUT cycles after the first WAIT entry; C unchanged from before the operation.
REQ-035 start re-asserted every cycle during an operation -> ignored; exactly one done pulse; the next start in IDLE is accepted.
REQ-036 rst asserted during WAIT of p=4 -> all outputs 0 asynchronously; a late mul_done is ignored; a new operation with A=I and B=[[9,8],[7,6]] yields C=B.
REQ-037 Spurious mul_done in IDLE and in ISSUE -> no state change, no C update.

Source files
------------

// File: rtl/matmul2x2_sched_if.sv
// matmul2x2_sched_if: operand/result bus plus the shared-multiplier handshake
interface matmul2x2_sched_if #(parameter int W = 8);
   logic                 start;
   logic [4*W-1:0]       a_flat, b_flat;
   logic [4*(2*W+1)-1:0] c_flat;
   logic                 busy, done, err;
   logic                 mul_start, mul_done;
   logic [W-1:0]         mul_a, mul_b;
   logic [2*W-1:0]       mul_result;
   modport slave (
      input  start, a_flat, b_flat, mul_result, mul_done,
      output c_flat, busy, done, err, mul_start, mul_a, mul_b
   );
   modport master (
      output start, a_flat, b_flat, mul_result, mul_done,
      input  c_flat, busy, done, err, mul_start, mul_a, mul_b
   );
endinterface

// File: rtl/matmul2x2_sched.sv
// matmul2x2_sched: unsigned 2x2 matrix product, eight products issued in turn to one external multiplier
module matmul2x2_sched #(
   parameter int W       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   matmul2x2_sched_if.slave bus
);
   localparam int CW = 2*W+1;
   localparam int TW = $clog2(TIMEOUT+1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
   state_t          state_q, state_d;
   logic [4*W-1:0]  a_q, a_d, b_q, b_d;
   logic [4*CW-1:0] c_q, c_d;
   logic [CW-1:0]   acc_q, acc_d;
   logic [2:0]      p_q, p_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic [1:0]      ia, ib;
   // p = {i, j, k}: A is read at (i,k), B at (k,j)
   assign ia = {p_q[2], p_q[0]};
   assign ib = {p_q[0], p_q[1]};
   assign bus.busy      = (state_q == ISSUE) || (state_q == WAIT);
   assign bus.done      = state_q == FIN;
   assign bus.mul_start = state_q == ISSUE;
   assign bus.mul_a     = a_q[W*ia +: W];
   assign bus.mul_b     = b_q[W*ib +: W];
   assign bus.c_flat    = c_q;
   assign bus.err       = err_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      acc_d   = acc_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE:
            if (bus.start) begin
               a_d     = bus.a_flat;
               b_d     = bus.b_flat;
               err_d   = 1'b0;
               p_d     = '0;
               state_d = ISSUE;
            end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT:
            if (bus.mul_done) begin
               if (p_q[0]) c_d[CW*p_q[2:1] +: CW] = acc_q + CW'(bus.mul_result);
               else acc_d = CW'(bus.mul_result);
               p_d     = p_q + 3'd1;
               state_d = (p_q == 3'd7) ? FIN : ISSUE;
            end else if (cnt_q == TW'(TIMEOUT-1)) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else cnt_d = cnt_q + TW'(1);
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_matmul2x2_sched.sv
// tb_matmul2x2_sched: directed and randomized operations checked against a plain-arithmetic matrix product
module tb_matmul2x2_sched;
   localparam int W = 8, TO = 20, CW = 2*W+1;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   matmul2x2_sched_if #(.W(W)) bus ();
   matmul2x2_sched #(.W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int n_edge = 0, n_ms = 0, n_done = 0;
   int lat = 1;
   bit spur_issue = 0, pend = 0;
   int rcnt = 0;
   logic r_done = 0, s_done = 0;
   logic [2*W-1:0] r_res = '0, s_res = '0, prod = '0;
   logic [4*CW-1:0] c_exp = '0;

   assign bus.mul_done   = r_done | s_done;
   assign bus.mul_result = s_done ? s_res : r_res;

   // multiplier model: answers L cycles into WAIT; lat 0 never answers
   always @(negedge clk) begin
      r_done = 0;
      if (rst) pend = 0;
      else begin
         if (pend) begin
            rcnt--;
            if (rcnt == 0) begin r_done = 1; r_res = prod; pend = 0; end
         end
         if (bus.mul_start && lat > 0) begin
            pend = 1; rcnt = lat; prod = bus.mul_a * bus.mul_b;
            if (spur_issue) begin r_done = 1; r_res = ~prod; end
         end
      end
   end

   always @(posedge clk) begin
      n_edge++;
      n_ms   += int'(bus.mul_start);
      n_done += int'(bus.done);
   end

   function automatic logic [4*CW-1:0] ref_mm(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
      logic [4*CW-1:0] c = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            int unsigned s = 0;
            for (int k = 0; k < 2; k++) s += a[W*(2*i+k) +: W] * b[W*(2*k+j) +: W];
            c[CW*(2*i+j) +: CW] = CW'(s);
         end
      return c;
   endfunction

   function automatic logic [4*W-1:0] pk(input int m00, input int m01, input int m10, input int m11);
      return {W'(m11), W'(m10), W'(m01), W'(m00)};
   endfunction

   task automatic chk(input string tag, input logic [4*CW-1:0] obs, input logic [4*CW-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [4*W-1:0] a, input logic [4*W-1:0] b, input int l, input bit spam, input bit spur);
      int e_s, ms0, d0, k;
      logic [4*CW-1:0] r = ref_mm(a, b);
      bit to = (l == 0);
      lat = l; spur_issue = spur;
      bus.a_flat = a; bus.b_flat = b; bus.start = 1;
      e_s = n_edge; ms0 = n_ms; d0 = n_done;
      @(negedge clk);
      chk("busy_after_accept", bus.busy, 1);
      chk("err_cleared", bus.err, 0);
      bus.start = spam; bus.a_flat = $urandom; bus.b_flat = $urandom;
      k = 0;
      while (!bus.done && k < 400) begin @(negedge clk); k++; end
      bus.start = 0;
      chk("latency", n_edge - e_s, to ? TO + 2 : 8 * (1 + l) + 1);
      chk("fin_busy", bus.busy, 0);
      chk("fin_err", bus.err, to);
      if (!to) c_exp = r;
      chk("c_result", bus.c_flat, c_exp);
      @(negedge clk);
      chk("done_low", bus.done, 0);
      chk("done_count", n_done - d0, 1);
      chk("mul_start_count", n_ms - ms0, to ? 1 : 8);
      chk("err_hold", bus.err, to);
      spur_issue = 0;
   endtask

   initial begin
      int k, ms0, d0;
      bus.start = 0; bus.a_flat = '0; bus.b_flat = '0;
      repeat (2) @(negedge clk);
      chk("rst_c", bus.c_flat, 0);
      chk("rst_ctl", {bus.busy, bus.done, bus.err, bus.mul_start}, 0);
      chk("rst_ops", {bus.mul_a, bus.mul_b}, 0);
      rst = 0;
      @(negedge clk);
      s_res = 16'hABCD; s_done = 1;
      @(negedge clk);
      s_done = 0;
      chk("idle_spur_busy", bus.busy, 0);
      chk("idle_spur_c", bus.c_flat, 0);
      run_op(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 3, 0, 0);
      chk("known_c", bus.c_flat, {17'd50, 17'd43, 17'd22, 17'd19});
      run_op(pk(255, 255, 255, 255), pk(255, 255, 255, 255), 2, 0, 0);
      chk("max_c", bus.c_flat, {4{17'h1FC02}});
      for (int n = 0; n < 6; n++) run_op($urandom, $urandom, $urandom_range(1, 4), 0, n == 3);
      run_op($urandom, $urandom, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("err_sticky", bus.err, 1);
      run_op($urandom, $urandom, 1, 1, 0);
      // abandon an operation while waiting on product p=4
      lat = 3; bus.a_flat = $urandom; bus.b_flat = $urandom; bus.start = 1;
      ms0 = n_ms; d0 = n_done;
      @(negedge clk);
      bus.start = 0; k = 0;
      while (!(n_ms - ms0 == 5 && bus.busy && !bus.mul_start) && k < 200) begin @(negedge clk); k++; end
      chk("reach_p4", n_ms - ms0, 5);
      #2 rst = 1;
      #1;
      chk("async_rst_ctl", {bus.busy, bus.done, bus.err, bus.mul_start}, 0);
      chk("async_rst_ops", {bus.mul_a, bus.mul_b}, 0);
      chk("async_rst_c", bus.c_flat, 0);
      c_exp = '0;
      @(negedge clk);
      #2 rst = 0;
      @(negedge clk);
      s_res = 16'hFFFF; s_done = 1;
      @(negedge clk);
      s_done = 0;
      @(negedge clk);
      chk("late_done_busy", bus.busy, 0);
      chk("late_done_c", bus.c_flat, 0);
      chk("no_done_after_rst", n_done - d0, 0);
      run_op(pk(1, 0, 0, 1), pk(9, 8, 7, 6), 1, 0, 0);
      chk("identity_c", bus.c_flat, {17'd6, 17'd7, 17'd8, 17'd9});
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
